relu_frame_scheduler: RTL



---
 rtl/relu_frame_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/relu_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : relu_frame_scheduler
// Description : Time-multiplexed ReLU stage. A full frame of SIZE signed
//               fixed-point values is captured through a valid/ready
//               handshake, passed through a LANES-wide ReLU slice one chunk
//               per cycle, then presented downstream as a complete frame
//               through a second valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   upstream frame valid
//   in_ready_o   frame can be accepted this cycle (combinational on out_ready_i)
//   in_data_i    input frame, SIZE x WIDTH two's-complement values
//   out_valid_o  activated frame available
//   out_ready_i  downstream accepts the frame
//   out_data_o   activated frame, stable while out_valid_o is high
//   busy_o       chunks are being processed
//   chunk_idx_o  chunk currently being processed (debug)
// ============================================================================
module relu_frame_scheduler #(
    parameter int WIDTH  = 10,
    parameter int NFRAC  = 5,
    parameter int SIZE   = 32,
    parameter int LANES  = 8,
    localparam int NCHUNK = SIZE / LANES,
    localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [SIZE-1:0][WIDTH-1:0] in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [SIZE-1:0][WIDTH-1:0] out_data_o,
    output logic                       busy_o,
    output logic [CIDX_W-1:0]          chunk_idx_o
);

    // NFRAC only describes the number format; it is checked here so an
    // inconsistent configuration is caught at elaboration.
    if ((NFRAC > WIDTH) || ((SIZE % LANES) != 0)) begin : g_param_check
        $error("relu_frame_scheduler: illegal NFRAC/SIZE/LANES combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PROC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [CIDX_W-1:0]            chunk_q, chunk_d;
    logic [SIZE-1:0][WIDTH-1:0]   inbuf_q, inbuf_d;
    logic [SIZE-1:0][WIDTH-1:0]   out_q,   out_d;

    logic [LANES-1:0][WIDTH-1:0]  w_lane_in;
    logic [LANES-1:0][WIDTH-1:0]  w_lane_out;
    logic                         w_last_chunk;

    assign w_last_chunk = (chunk_q == CIDX_W'(NCHUNK - 1));

    // Select the active chunk of the input buffer so only LANES ReLU
    // comparators are needed regardless of SIZE.
    always_comb begin
        w_lane_in = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            if (chunk_q == CIDX_W'(c)) begin
                w_lane_in = inbuf_q[c*LANES +: LANES];
            end
        end
    end

    // ReLU: negative values (sign bit set) clamp to zero, all others pass.
    always_comb begin
        w_lane_out = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_out[l] = w_lane_in[l][WIDTH-1] ? '0 : w_lane_in[l];
        end
    end

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        inbuf_d = inbuf_q;
        out_d   = out_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    inbuf_d = in_data_i;
                    chunk_d = '0;
                    state_d = S_PROC;
                end
            end

            S_PROC: begin
                for (int c = 0; c < NCHUNK; c++) begin
                    if (chunk_q == CIDX_W'(c)) begin
                        out_d[c*LANES +: LANES] = w_lane_out;
                    end
                end
                if (w_last_chunk) begin
                    chunk_d = '0;
                    state_d = S_DONE;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end

            S_DONE: begin
                // A new frame may be taken on the same edge the current
                // one is handed off, giving back-to-back throughput.
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        inbuf_d = in_data_i;
                        chunk_d = '0;
                        state_d = S_PROC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                chunk_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            chunk_q <= '0;
            inbuf_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            inbuf_q <= inbuf_d;
            out_q   <= out_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q == S_PROC);
    assign out_data_o  = out_q;
    assign chunk_idx_o = chunk_q;

endmodule
`default_nettype wire
